// File: rtl/color_effect_pipe.sv
// color_effect_pipe: 3-stage centre-pixel colour effect pipeline (passthrough/grayscale/invert/threshold) with output pixel counter.
// Ports: clk, reset (async, active-high); color_data/in_valid/in_ready 3x3 window input (centre in MSBs);
// mode/thr effect select sampled with each pixel; filter_rgb_out/out_valid/out_ready registered pixel output;
// pix_count completed output transfers. Macro COLOR_EFFECT_THRESHOLD_EN enables mode 3 threshold, else mode 3 passes through.
module color_effect_pipe #(
  parameter int CW = 4,
  parameter int CNT_W = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [27*CW-1:0]   color_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic [CW-1:0]      thr,
  output logic [3*CW-1:0]    filter_rgb_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   pix_count
);
  localparam int PW = 3*CW;
  localparam int YW = CW+9;
  localparam logic [YW-1:0] YMAX = YW'(2**CW-1);
  logic en, v1, v2;
  logic [PW-1:0] p1, p2, fx;
  logic [1:0] m1, m2;
  logic [CW-1:0] y, y2;
  logic [YW-1:0] y_sum, y_sh;
  logic unused_bits;
`ifdef COLOR_EFFECT_THRESHOLD_EN
  logic [CW-1:0] t1, t2;
  assign unused_bits = ^color_data[8*PW-1:0];
`else
  assign unused_bits = ^{color_data[8*PW-1:0], thr};
`endif
  // one enable for every stage: the whole pipe stalls only when the output is blocked
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  always_comb begin
    y_sum = YW'(77)*YW'(p1[PW-1 -: CW]) + YW'(150)*YW'(p1[2*CW-1 -: CW]) + YW'(29)*YW'(p1[CW-1:0]) + YW'(128);
    y_sh = y_sum >> 8;
    y = (y_sh > YMAX) ? YMAX[CW-1:0] : y_sh[CW-1:0];
  end
  // per-channel (2^CW-1)-c is a plain bitwise inversion
  assign fx = (m2 == 2'd1) ? {3{y2}} :
              (m2 == 2'd2) ? ~p2 :
`ifdef COLOR_EFFECT_THRESHOLD_EN
              (m2 == 2'd3) ? {PW{y2 >= t2}} :
`endif
              p2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      filter_rgb_out <= '0;
      pix_count <= '0;
    end else begin
      if (out_valid && out_ready) pix_count <= pix_count + CNT_W'(1);
      if (en) begin
        v1 <= in_valid;
        v2 <= v1;
        out_valid <= v2;
        if (v2) filter_rgb_out <= fx;
      end
    end
  end
  // payload registers need no reset: their valid bits gate them
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      p1 <= color_data[9*PW-1 -: PW];
      m1 <= mode;
`ifdef COLOR_EFFECT_THRESHOLD_EN
      t1 <= thr;
`endif
    end
    if (en && v1) begin
      p2 <= p1;
      m2 <= m1;
      y2 <= y;
`ifdef COLOR_EFFECT_THRESHOLD_EN
      t2 <= t1;
`endif
    end
  end
endmodule

// File: tb/tb_color_effect_pipe.sv
module tb_color_effect_pipe;
  localparam int CW = 4;
  localparam int CNT_W = 19;
  logic clk = 0, reset = 1;
  logic [27*CW-1:0] color_data = '0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [1:0] mode = 0;
  logic [CW-1:0] thr = 0;
  logic [3*CW-1:0] filter_rgb_out;
  logic [CNT_W-1:0] pix_count;
  int n_vec = 0, n_err = 0, cyc = 0, last_stall = -100, exp_cnt = 0;
  typedef struct { logic [11:0] px; int cyc; } ent_t;
  ent_t q[$];
  logic prev_stall = 0;
  logic [11:0] prev_data;

  color_effect_pipe #(.CW(CW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .color_data(color_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .thr(thr), .filter_rgb_out(filter_rgb_out), .out_valid(out_valid),
    .out_ready(out_ready), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic [11:0] px, input logic [1:0] md, input logic [3:0] th);
    int r, g, b, yy;
    r = px[11:8]; g = px[7:4]; b = px[3:0];
    yy = (77*r + 150*g + 29*b + 128) / 256;
    if (yy > 15) yy = 15;
    case (md)
      2'd1: return 12'(yy*273);
      2'd2: return 12'(4095 - px);
`ifdef COLOR_EFFECT_THRESHOLD_EN
      2'd3: return (yy >= th) ? 12'hFFF : 12'h000;
`endif
      default: return px;
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      exp_cnt = 0;
      prev_stall = 0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      chk("pix_count", pix_count, exp_cnt);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", filter_rgb_out, prev_data);
      end
      if (in_valid && in_ready) q.push_back('{model(color_data[107:96], mode, thr), cyc});
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          ent_t e;
          e = q.pop_front();
          chk("model_out", filter_rgb_out, e.px);
          if (last_stall < e.cyc) chk("latency", cyc - e.cyc, 3);
          exp_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) last_stall = cyc;
      prev_data = filter_rgb_out;
    end
  end

  task automatic drive(input logic [11:0] px, input logic [1:0] md, input logic [3:0] th);
    color_data = {px, $urandom(), $urandom(), $urandom()};
    mode = md; thr = th; in_valid = 1;
  endtask

  task automatic scramble();
    in_valid = 0;
    mode = 2'($urandom());
    thr = 4'($urandom());
    color_data = {$urandom(), $urandom(), $urandom(), 12'($urandom())};
  endtask

  task automatic send_one(input logic [11:0] px, input logic [1:0] md, input logic [3:0] th,
                          input logic [11:0] exp, input string nm);
    int k;
    @(posedge clk); #1;
    drive(px, md, th);
    @(posedge clk); #1;
    scramble();
    for (k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk({nm, "_lat"}, k, 3);
    chk(nm, filter_rgb_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] px[10];
    int i, c, k;
    // reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", filter_rgb_out, 0);
    chk("rst_count", pix_count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    // model pins
    chk("model_gray_red", model(12'hF00, 1, 0), 12'h555);
    chk("model_inv", model(12'h3A7, 2, 0), 12'hC58);
    // directed single pixels
    send_one(12'hF00, 1, 0, 12'h555, "gray_red");
    send_one(12'hFFF, 1, 0, 12'hFFF, "gray_white");
    send_one(12'h3A7, 2, 0, 12'hC58, "invert");
    send_one(12'h3A7, 0, 0, 12'h3A7, "pass");
    send_one(12'h000, 1, 0, 12'h000, "gray_black");
`ifdef COLOR_EFFECT_THRESHOLD_EN
    send_one(12'h0F0, 3, 8, 12'hFFF, "thr8");
    send_one(12'h0F0, 3, 10, 12'h000, "thr10");
    send_one(12'h0F0, 3, 9, 12'hFFF, "thr9_eq");
`else
    send_one(12'h0F0, 3, 8, 12'h0F0, "thr8_off");
    send_one(12'h0F0, 3, 10, 12'h0F0, "thr10_off");
`endif
    // mode switch between consecutive pixels
    @(posedge clk); #1; drive(12'hF00, 1, 0);
    @(posedge clk); #1; drive(12'hF00, 2, 0);
    @(posedge clk); #1; scramble();
    for (k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("switch_first", filter_rgb_out, 12'h555);
    @(negedge clk);
    chk("switch_second", filter_rgb_out, 12'h0FF);
    // stream with back-pressure, from a clean count
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1; reset = 0;
    for (int j = 0; j < 10; j++) px[j] = 12'($urandom());
    i = 0; c = 0;
    while (i < 10 && c < 40) begin
      @(posedge clk); #1;
      out_ready = !(c >= 4 && c <= 7);
      if (i < 10) drive(px[i], 2'(i), 4'(i)); else scramble();
      @(negedge clk);
      if (c >= 4 && c <= 7) chk("stall_in_ready", in_ready, 0);
      if (in_valid && in_ready) i++;
      c++;
    end
    @(posedge clk); #1; scramble(); out_ready = 1;
    for (k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("stream_drained", q.size(), 0);
    chk("stream_count", pix_count, 10);
    // reset with three pixels in flight
    @(posedge clk); #1; drive(12'h123, 2, 0);
    @(posedge clk); #1; drive(12'h456, 2, 0);
    @(posedge clk); #1; drive(12'h789, 2, 0);
    @(posedge clk); #1; scramble();
    chk("pre_rst_valid", out_valid, 1);
    #2 reset = 1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_count", pix_count, 0);
    chk("async_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1; reset = 0;
    c = 0;
    for (k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) c++;
    end
    chk("no_stale", c, 0);
    send_one(12'hABC, 0, 0, 12'hABC, "first_after_rst");
    @(negedge clk);
    chk("count_after_rst", pix_count, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
